// File: rtl/tdes_pkg.sv
// rtl/tdes_pkg.sv - shared types, constants and pass key/direction lookup for the TDES round sequencer (honours TDES_KEYING_OPT2_EN)
package tdes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DONE
    } state_t;

    localparam int ROUNDS_DEFAULT = 16;

    localparam logic [1:0] KEY1 = 2'd0;
    localparam logic [1:0] KEY2 = 2'd1;
    localparam logic [1:0] KEY3 = 2'd2;

    typedef struct packed {
        logic [1:0] key;
        logic       dec;
    } pass_cfg_t;

    // EDE ordering: encrypt runs K1/K2/K3 as enc/dec/enc, decrypt mirrors it
    function automatic pass_cfg_t pass_cfg(input logic mode, input logic [1:0] pass);
        pass_cfg_t c;
        c = '0;
        c.dec = mode ? ~pass[0] : pass[0];
        case (pass)
            2'd0:    c.key = mode ? KEY3 : KEY1;
            2'd1:    c.key = KEY2;
            default: c.key = mode ? KEY1 : KEY3;
        endcase
`ifdef TDES_KEYING_OPT2_EN
        if (c.key == KEY3) begin
            c.key = KEY1;
        end
`endif
        return c;
    endfunction

endpackage

// File: rtl/tdes_round_counter.sv
// rtl/tdes_round_counter.sv - 4-bit Feistel round counter with clear, enable and terminal-count flag
module tdes_round_counter
    import tdes_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count,
    output logic       tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == 4'(ROUNDS - 1));

endmodule

// File: rtl/tdes_round_sequencer.sv
// rtl/tdes_round_sequencer.sv - TDES EDE round sequencing FSM driving datapath strobes and key-schedule selects (TDES_KEYING_OPT2_EN selects two-key TDES)
module tdes_round_sequencer
    import tdes_pkg::*;
#(
    parameter int NUM_PASSES = 3,
    parameter int ROUNDS     = ROUNDS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mode,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic       dp_final,
    output logic [1:0] key_idx,
    output logic [3:0] subkey_num,
    output logic       key_decrypt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    state_t     state, state_n;
    logic [1:0] pass;
    logic       mode_r;
    logic [3:0] round;
    logic       round_tc;
    logic       accept;
    logic       last_pass;
    logic       active;
    pass_cfg_t  cfg;

    assign accept    = in_valid & in_ready;
    assign last_pass = (pass == 2'(NUM_PASSES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pass   <= '0;
            mode_r <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                mode_r <= mode;
                pass   <= '0;
            end else if (state == ROUND && round_tc && !last_pass) begin
                pass <= pass + 2'd1;
            end
        end
    end

    // Clearing at terminal count leaves round at 0 for the next LOAD
    tdes_round_counter #(
        .ROUNDS(ROUNDS)
    ) u_round_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept | (state == ROUND && round_tc)),
        .en   (state == ROUND),
        .count(round),
        .tc   (round_tc)
    );

    always_comb begin
        state_n     = state;
        in_ready    = 1'b0;
        dp_load     = 1'b0;
        dp_round_en = 1'b0;
        dp_final    = 1'b0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                dp_load = 1'b1;
                state_n = ROUND;
            end
            ROUND: begin
                dp_round_en = 1'b1;
                if (round_tc) begin
                    dp_final = 1'b1;
                    state_n  = last_pass ? DONE : LOAD;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign active = (state == LOAD) || (state == ROUND);

    always_comb begin
        cfg = pass_cfg(mode_r, pass);
        if (NUM_PASSES == 1) begin
            cfg.key = KEY1;
            cfg.dec = mode_r;
        end
    end

    assign key_idx     = active ? cfg.key : 2'd0;
    assign key_decrypt = active & cfg.dec;
    assign subkey_num  = !active ? 4'd0 : (cfg.dec ? 4'(ROUNDS - 1) - round : round);

endmodule

// File: tb/tb_tdes_round_sequencer.sv
// tb/tb_tdes_round_sequencer.sv - scoreboard bench for tdes_round_sequencer with randomized blocks and reference pass model
module tb_tdes_round_sequencer;

    localparam int NP = 3;
    localparam int R  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic       dp_load;
    logic       dp_round_en;
    logic       dp_final;
    logic [1:0] key_idx;
    logic [3:0] subkey_num;
    logic       key_decrypt;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    tdes_round_sequencer #(
        .NUM_PASSES(NP),
        .ROUNDS    (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .dp_load    (dp_load),
        .dp_round_en(dp_round_en),
        .dp_final   (dp_final),
        .key_idx    (key_idx),
        .subkey_num (subkey_num),
        .key_decrypt(key_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       load;
        logic       fin;
        logic [1:0] key;
        logic [3:0] sk;
        logic       dec;
    } step_t;

    step_t exp_q[$];
    int    exp_out_q[$];
    int    tests = 0;
    int    fails = 0;
    logic  mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key/direction per pass straight from the EDE schedule tables
    function automatic void model_key(input logic m, input int p, output logic [1:0] k, output logic d);
        int ek[3];
        int dk[3];
        ek = '{0, 1, 2};
        dk = '{2, 1, 0};
`ifdef TDES_KEYING_OPT2_EN
        ek = '{0, 1, 0};
        dk = '{0, 1, 0};
`endif
        if (NP == 1) begin
            k = 2'd0;
            d = m;
        end else begin
            k = m ? 2'(dk[p]) : 2'(ek[p]);
            d = m ? (p != 1) : (p == 1);
        end
    endfunction

    task automatic issue(input logic m, input int c);
        int         k;
        logic [1:0] kk;
        logic       d;
        k = 1;
        for (int p = 0; p < NP; p++) begin
            model_key(m, p, kk, d);
            exp_q.push_back('{c + k, 1'b1, 1'b0, kk, d ? 4'(R - 1) : 4'd0, d});
            k++;
            for (int r = 0; r < R; r++) begin
                exp_q.push_back('{c + k, 1'b0, (r == R - 1), kk, d ? 4'(R - 1 - r) : 4'(r), d});
                k++;
            end
        end
        exp_out_q.push_back(c + k);
    endtask

    initial begin
        logic  prev_ov;
        step_t s;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (dp_load || dp_round_en) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_strobe load=%0b round_en=%0b required none at cycle %0d",
                                 dp_load, dp_round_en, cyc);
                    end else begin
                        s = exp_q.pop_front();
                        chk("strobe_cycle", cyc, s.cyc);
                        chk("dp_load", dp_load, s.load);
                        chk("dp_round_en", dp_round_en, !s.load);
                        chk("dp_final", dp_final, s.fin);
                        chk("key_idx", key_idx, s.key);
                        chk("subkey_num", subkey_num, s.sk);
                        chk("key_decrypt", key_decrypt, s.dec);
                        chk("ov_during_strobe", out_valid, 0);
                    end
                end else begin
                    chk("inactive_selects", {dp_final, key_idx, subkey_num, key_decrypt}, 0);
                end
                if (out_valid && !prev_ov) begin
                    if (exp_out_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_out_valid at cycle %0d required none", cyc);
                    end else begin
                        chk("out_valid_cycle", cyc, exp_out_q.pop_front());
                    end
                end
                if (out_valid) begin
                    chk("done_flags", {busy, in_ready}, 2'b10);
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("wait_in_ready", in_ready, 1);
    endtask

    task automatic run_block(input logic m, input int hold);
        int n;
        wait_ready();
        in_valid = 1'b1;
        mode     = m;
        issue(m, cyc);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            in_valid  = 1'($urandom);
            mode      = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            n++;
        end
        in_valid  = 1'b1;
        mode      = 1'($urandom);
        out_ready = 1'b0;
        chk("out_valid_seen", out_valid, 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_state", {out_valid, busy, in_ready}, 3'b110);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("exit_to_idle", {out_valid, busy, in_ready}, 3'b001);
    endtask

    initial begin
        int c;
        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_outputs", {busy, out_valid, dp_load, dp_round_en, dp_final, key_idx, subkey_num, key_decrypt}, 0);
        mon_en = 1'b1;
        rst    = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("idle_state", {in_ready, busy, out_valid}, 3'b100);
            tick();
        end

        run_block(1'b0, 0);
        run_block(1'b1, 0);
        run_block(1'($urandom), 20);

        wait_ready();
        in_valid = 1'b1;
        mode     = 1'b0;
        c        = cyc;
        issue(1'b0, c);
        tick();
        in_valid = 1'b0;
        while (cyc < c + 30) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        exp_out_q.delete();
        chk("abort_state", {in_ready, busy, out_valid, dp_load, dp_round_en}, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_idle", {in_ready, busy, out_valid}, 3'b100);

        run_block(1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            run_block(1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (5) tick();
        chk("drain_steps", exp_q.size(), 0);
        chk("drain_outs", exp_out_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
